// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   port_e    : index of a requesting port (0 = CPU, 1 = DMA/debug)
//   state_e   : arbiter FSM states
//   mem_cmd_t : one port's command as presented to the data memory
//   ADDR_TOP_DEFAULT / MAX_LOCK_DEFAULT : default parameter values
//   addr_err  : true when a byte address lies above the legal range
package dmem_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } mem_cmd_t;

    localparam logic [31:0] ADDR_TOP_DEFAULT = 32'h0000_3FFF;
    localparam int unsigned MAX_LOCK_DEFAULT = 8;

    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] top);
        return addr > top;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   req/addr/wdata/we : request side, driven by the master, held until gnt
//   gnt               : access performed this cycle (combinational)
//   rvalid/rdata/err  : one-cycle response, the cycle after the grant
// master modport: the CPU or DMA side; slave modport: the arbiter side.
interface dmem_arbiter_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, wdata, we,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, wdata, we,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a last-granted pointer.
//   clk, reset : clock, synchronous active-low reset
//   req[1:0]   : requests (already qualified by the caller)
//   prio1      : give port 1 absolute priority this cycle (burst lock)
//   gnt[1:0]   : one-hot or zero grant, combinational
// The pointer tracks every grant, including those made under prio1, so
// a port 0 waiting behind a burst wins the first tie after the lock ends.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       prio1,
    output logic [1:0] gnt
);

    port_e last_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // Port 1 counts as last granted, so port 0 wins the first tie.
            last_reg <= PORT1;
        end else if (gnt[0]) begin
            last_reg <= PORT0;
        end else if (gnt[1]) begin
            last_reg <= PORT1;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (prio1 || (last_reg == PORT0)) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory with
// asynchronous read.
//   clk, reset     : clock, synchronous active-low reset
//   m0             : CPU port (dmem_arbiter_if.slave)
//   m1             : DMA/debug port (dmem_arbiter_if.slave)
//   m1_lock        : port 1 asks for back-to-back grants (burst)
//   mem_addr/wdata : address and write data to the memory
//   mem_we         : byte-write mask to the memory (0 = no write)
//   mem_rdata      : asynchronous read data from the memory
// Grants are combinational; a write commits at the edge that ends its
// grant cycle and every access (read, write or range error) returns a
// one-cycle rvalid the following cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_TOP = ADDR_TOP_DEFAULT,
    parameter int unsigned MAX_LOCK = MAX_LOCK_DEFAULT
)(
    input  logic               clk,
    input  logic               reset,
    dmem_arbiter_if.slave      m0,
    dmem_arbiter_if.slave      m1,
    input  logic               m1_lock,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_we,
    input  logic [31:0]        mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mem_cmd_t         cmd [2];
    logic [1:0]       req_vec;
    logic [1:0]       gnt_vec;
    logic [1:0]       err_vec;
    logic             prio1;

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    mem_cmd_t         sel_cmd;
    logic             sel_err;
    logic [31:0]      addr_hold_reg;
    logic [31:0]      wdata_hold_reg;

    assign cmd[0] = '{addr: m0.addr, wdata: m0.wdata, we: m0.we};
    assign cmd[1] = '{addr: m1.addr, wdata: m1.wdata, we: m1.we};

    // Requests are masked during reset so nothing is granted or written.
    assign req_vec = {m1.req, m0.req} & {2{reset}};
    assign prio1   = (state_reg == LOCK1) && m1_lock;

    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req_vec),
        .prio1 (prio1),
        .gnt   (gnt_vec)
    );

    assign m0.gnt = gnt_vec[0];
    assign m1.gnt = gnt_vec[1];

    // ------------------------------------------------------------------
    // Lock FSM: the counter includes the grant that entered LOCK1, so a
    // burst is at most MAX_LOCK grants long before port 0 gets a turn.
    // ------------------------------------------------------------------
    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ARB;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ARB: begin
                if (gnt_vec[1] && m1_lock && (CNT_MAX != CNT_ONE)) begin
                    state_next = LOCK1;
                    cnt_next   = CNT_ONE;
                end
            end
            LOCK1: begin
                if (gnt_vec[1]) begin
                    cnt_next = cnt_inc;
                end
                if (!m1_lock || !m1.req || (gnt_vec[1] && (cnt_inc == CNT_MAX))) begin
                    state_next = ARB;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ARB;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory side: mirror the granted port, otherwise hold the last
    // address/data with the write mask cleared.
    // ------------------------------------------------------------------
    always_comb begin
        sel_cmd = cmd[0];
        sel_err = err_vec[0];
        if (gnt_vec[1]) begin
            sel_cmd = cmd[1];
            sel_err = err_vec[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else if (|gnt_vec) begin
            addr_hold_reg  <= sel_cmd.addr;
            wdata_hold_reg <= sel_cmd.wdata;
        end
    end

    always_comb begin
        mem_addr  = addr_hold_reg;
        mem_wdata = wdata_hold_reg;
        mem_we    = '0;
        if (!reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (|gnt_vec) begin
            mem_addr  = sel_cmd.addr;
            mem_wdata = sel_cmd.wdata;
            // Out-of-range accesses are granted but never write.
            mem_we    = sel_err ? 4'b0000 : sel_cmd.we;
        end
    end

    // ------------------------------------------------------------------
    // Per-port response registers.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic        rvalid_reg;
            logic [31:0] rdata_reg;
            logic        err_reg;

            assign err_vec[gi] = addr_err(cmd[gi].addr, ADDR_TOP);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                    err_reg    <= 1'b0;
                end else begin
                    rvalid_reg <= gnt_vec[gi];
                    if (gnt_vec[gi]) begin
                        err_reg <= err_vec[gi];
                        // Writes and range errors answer with zero data.
                        if (err_vec[gi] || (cmd[gi].we != 4'b0000)) begin
                            rdata_reg <= '0;
                        end else begin
                            rdata_reg <= mem_rdata;
                        end
                    end
                end
            end
        end
    endgenerate

    // Responses are blanked while reset is low, which also drops a
    // response still pending from the cycle before reset.
    assign m0.rvalid = g_resp[0].rvalid_reg & reset;
    assign m0.rdata  = reset ? g_resp[0].rdata_reg : 32'h0;
    assign m0.err    = g_resp[0].err_reg & reset;
    assign m1.rvalid = g_resp[1].rvalid_reg & reset;
    assign m1.rdata  = reset ? g_resp[1].rdata_reg : 32'h0;
    assign m1.err    = g_resp[1].err_reg & reset;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_TOP, default 32'h0000_3FFF: highest legal byte address of the data memory.
REQ-002 SHALL have parameter MAX_LOCK, default 8: maximum consecutive locked grants to port 1.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  reset, synchronous, active-low.
REQ-005 m0_req  in  1  port 0 (CPU) access request; held until m0_gnt.
REQ-006 m0_addr  in  32  port 0 byte address.
REQ-007 m0_wdata  in  32  port 0 write data.
REQ-008 m0_we  in  4  port 0 byte-write mask; 0 = read.
REQ-009 m0_gnt  out  1  port 0 access performed this cycle.
REQ-010 m0_rvalid  out  1  port 0 response valid, one cycle.
REQ-011 m0_rdata  out  32  port 0 read data, valid with m0_rvalid.
REQ-012 m0_err  out  1  port 0 address-range error, valid with m0_rvalid.
REQ-013 m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1 (DMA/debug).
REQ-014 m1_lock  in  1  port 1 requests back-to-back grants (burst).
REQ-015 mem_addr  out  32  address to data memory.
REQ-016 mem_wdata  out  32  write data to data memory.
REQ-017 mem_we  out  4  byte-write mask to data memory.
REQ-018 mem_rdata  in  32  asynchronous read data from data memory.

Function
REQ-019 Grant SHALL be combinational: at most one of m0_gnt/m1_gnt high per cycle, only for a port whose req is high.
REQ-020 In a grant cycle, mem_addr/mem_wdata/mem_we SHALL mirror the granted port; with no grant, mem_we = 0 and mem_addr/mem_wdata hold their last values.
REQ-021 A write SHALL commit at the posedge ending the grant cycle.
REQ-022 Reads SHALL return mem_rdata, registered at the grant-cycle edge; rvalid high exactly one cycle later.
REQ-023 Writes SHALL also produce a one-cycle rvalid with rdata = 0.
REQ-024 If the address is greater than ADDR_TOP: grant, force mem_we = 0, and return rvalid with err = 1 and rdata = 0.
REQ-025 Arbitration SHALL be round-robin: if both ports request, grant the port not granted last; single requester always granted.
REQ-026 FSM states: ARB (round-robin) and LOCK1. ARB->LOCK1 when port 1 is granted with m1_lock = 1.
REQ-027 In LOCK1, port 1 SHALL have absolute priority; the lock counter SHALL increment on each port 1 grant.
REQ-028 LOCK1->ARB when m1_lock = 0, or m1_req = 0, or the counter reaches MAX_LOCK.
REQ-029 On leaving LOCK1 via MAX_LOCK with m0_req high, port 0 SHALL be granted next cycle before port 1 re-locks.
REQ-030 Back-to-back grants to the same port SHALL be allowed, with no idle cycle.
REQ-031 rvalid of one access SHALL coincide with the grant of the next; responses stay in order per port.

Reset
REQ-032 While reset = 0, all outputs 0 except mem_addr/mem_wdata = 0, mem_we = 0, gnt = 0, rvalid = 0.
REQ-033 After reset: FSM = ARB, lock counter = 0, last-grant pointer = port 1 (port 0 wins first tie).
REQ-034 Reset asserted mid-operation SHALL drop any pending rvalid; no write is committed in the reset cycle.

Structure
REQ-035 Port index encoding, FSM state encoding and the default ADDR_TOP SHALL live in the shared package dmem_pkg.
REQ-036 One sub-module rr_arb2 (2-way round-robin grant with pointer) is natural; the FSM, lock counter and response registers stay in dmem_arbiter.

Verification
REQ-037 m0 read 0x10 alone -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata = memory word at 0x10.
REQ-038 Both ports write in the same cycle from reset -> m0 granted first, m1 next cycle; both writes visible on readback.
REQ-039 m1 burst with m1_lock = 1 for 12 requests while m0_req held -> 8 m1 grants, then 1 m0 grant, then m1 resumes.
REQ-040 m0 write to 0x4000 -> mem_we = 0, m0_err = 1, m0_rdata = 0, memory unchanged.
REQ-041 reset = 0 in the cycle after a grant -> no rvalid, mem_we = 0; the first post-reset tie goes to port 0.
